// File: rtl/boa_pmu_ctrl.sv
// rtl/boa_pmu_ctrl.sv - power-management controller: button debounce, reset hold, shutdown/wake sequencing
module boa_pmu_ctrl #(
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int RST_HOLD_CYCLES    = 8,
  parameter int WAKE_SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_rst,
  input  logic       btn_wake,
  input  logic       shdn_req,
  input  logic       rst_req,
  output logic       core_rst,
  output logic       clk_gate,
  output logic       wake_evt,
  output logic [1:0] pmu_state
);

  localparam int MAX_CNT = (RST_HOLD_CYCLES > WAKE_SETTLE_CYCLES) ? RST_HOLD_CYCLES : WAKE_SETTLE_CYCLES;
  localparam int CW = $clog2(MAX_CNT + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(WAKE_SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_SHDN  = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  // Bit 0 carries the reset button, bit 1 the wake button.
  logic [1:0]    sync1, sync2, level, press;
  logic [DW-1:0] db_cnt [2];

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          evt_nxt;
  logic          rst_any;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {btn_wake, btn_rst};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the edge on which the debounced level is about to rise.
  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++) begin
      press[i] = sync2[i] & ~level[i] & (db_cnt[i] == DB_LAST);
    end
  end

  assign rst_any = press[0] | rst_req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    evt_nxt   = 1'b0;
    case (state)
      ST_RESET: begin
        if (rst_any)          cnt_nxt = HOLD_LOAD;
        else if (cnt == '0)   state_nxt = ST_RUN;
        else                  cnt_nxt = cnt - 1'b1;
      end
      ST_RUN: begin
        if (rst_any) begin
          state_nxt = ST_RESET;
          cnt_nxt   = HOLD_LOAD;
        end else if (shdn_req) begin
          state_nxt = ST_SHDN;
        end
      end
      ST_SHDN: begin
        if (rst_any) begin
          state_nxt = ST_RESET;
          cnt_nxt   = HOLD_LOAD;
        end else if (press[1]) begin
          state_nxt = ST_WAKE;
          cnt_nxt   = SETTLE_LOAD;
        end
      end
      ST_WAKE: begin
        if (rst_any) begin
          state_nxt = ST_RESET;
          cnt_nxt   = HOLD_LOAD;
        end else if (cnt == '0) begin
          state_nxt = ST_RUN;
          evt_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RESET;
        cnt_nxt   = HOLD_LOAD;
      end
    endcase
  end

  // Outputs are flopped from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      cnt       <= HOLD_LOAD;
      core_rst  <= 1'b1;
      clk_gate  <= 1'b0;
      wake_evt  <= 1'b0;
      pmu_state <= 2'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      core_rst  <= (state_nxt == ST_RESET);
      clk_gate  <= (state_nxt == ST_SHDN);
      wake_evt  <= evt_nxt;
      pmu_state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_boa_pmu_ctrl.sv
// tb/tb_boa_pmu_ctrl.sv - self-checking bench for boa_pmu_ctrl with a behavioural reference model
module tb_boa_pmu_ctrl;
  localparam int D = 16;
  localparam int H = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n, btn_rst, btn_wake, shdn_req, rst_req;
  logic core_rst, clk_gate, wake_evt;
  logic [1:0] pmu_state;

  int n_cmp = 0;
  int n_err = 0;

  boa_pmu_ctrl #(.DEBOUNCE_CYCLES(D), .RST_HOLD_CYCLES(H), .WAKE_SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .btn_rst(btn_rst), .btn_wake(btn_wake),
    .shdn_req(shdn_req), .rst_req(rst_req), .core_rst(core_rst),
    .clk_gate(clk_gate), .wake_evt(wake_evt), .pmu_state(pmu_state)
  );

  always #5 clk = ~clk;

  // Reference model: states as plain ints, reset/settle tracked as "cycles left including this one".
  localparam int M_RESET = 0, M_RUN = 1, M_SHDN = 2, M_WAKE = 3;
  int m_state, m_left;
  bit m_evt;
  bit m_raw_d1 [2], m_raw_d2 [2], m_lvl [2];
  int m_run [2];

  task automatic model_edge();
    bit raw [2];
    bit pr [2];
    bit rst_ev;
    raw[0] = btn_rst;
    raw[1] = btn_wake;
    if (!rst_n) begin
      m_state = M_RESET; m_left = H; m_evt = 0;
      for (int i = 0; i < 2; i++) begin
        m_raw_d1[i] = 0; m_raw_d2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      pr[i] = 0;
      if (m_raw_d2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = !m_lvl[i];
          m_run[i] = 0;
          pr[i] = m_lvl[i];
        end
      end else begin
        m_run[i] = 0;
      end
      m_raw_d2[i] = m_raw_d1[i];
      m_raw_d1[i] = raw[i];
    end
    rst_ev = pr[0] || rst_req;
    m_evt = 0;
    if (rst_ev) begin
      m_state = M_RESET; m_left = H;
    end else begin
      case (m_state)
        M_RESET: if (m_left == 1) m_state = M_RUN; else m_left--;
        M_RUN:   if (shdn_req) m_state = M_SHDN;
        M_SHDN:  if (pr[1]) begin m_state = M_WAKE; m_left = S; end
        default: if (m_left == 1) begin m_state = M_RUN; m_evt = 1; end else m_left--;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_state", 32'(pmu_state), 32'(m_state));
    chk("model_core_rst", 32'(core_rst), 32'(m_state == M_RESET));
    chk("model_clk_gate", 32'(clk_gate), 32'(m_state == M_SHDN));
    chk("model_wake_evt", 32'(wake_evt), 32'(m_evt));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Counts the current and following cycles with core_rst high; bounded.
  task automatic count_rst(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!core_rst) break;
      n++;
      tick();
    end
  endtask

  int n, w, e;

  initial begin
    rst_n = 0; btn_rst = 0; btn_wake = 0; shdn_req = 0; rst_req = 0;
    #1;
    ticks(3);
    chk("rst_pmu_state", 32'(pmu_state), 0);
    chk("rst_core_rst", 32'(core_rst), 1);
    chk("rst_wake_evt", 32'(wake_evt), 0);

    // Power-up hold
    rst_n = 1;
    count_rst(n);
    chk("por_hold_cycles", n, H);
    chk("por_run", 32'(pmu_state), 1);

    // Shutdown then wake
    shdn_req = 1; tick(); shdn_req = 0;
    chk("shdn_gate", 32'(clk_gate), 1);
    chk("shdn_state", 32'(pmu_state), 2);
    btn_wake = 1;
    w = 0; e = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pmu_state == 2'd3) w++;
      if (wake_evt) e++;
    end
    btn_wake = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (wake_evt) e++;
    end
    chk("wake_cycles", w, S);
    chk("wake_evt_count", e, 1);
    chk("wake_back_run", 32'(pmu_state), 1);
    chk("wake_ungated", 32'(clk_gate), 0);

    // Debounce glitches never reach the FSM
    n = 0;
    btn_rst = 1;
    for (int i = 0; i < 15; i++) begin tick(); if (core_rst) n++; end
    btn_rst = 0; tick(); if (core_rst) n++;
    btn_rst = 1;
    for (int i = 0; i < 15; i++) begin tick(); if (core_rst) n++; end
    btn_rst = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (core_rst) n++; end
    chk("glitch_no_reset", n, 0);
    btn_rst = 1;
    ticks(17);
    chk("btn_rst_before", 32'(pmu_state), 1);
    tick();
    chk("btn_rst_enter", 32'(pmu_state), 0);
    count_rst(n);
    chk("btn_rst_hold", n, H);
    btn_rst = 0;
    ticks(25);

    // Reset beats shutdown; reset from shutdown ungates at once
    rst_req = 1; shdn_req = 1; tick(); rst_req = 0; shdn_req = 0;
    chk("prio_state", 32'(pmu_state), 0);
    chk("prio_gate", 32'(clk_gate), 0);
    ticks(10);
    shdn_req = 1; tick(); shdn_req = 0;
    chk("shdn_again", 32'(pmu_state), 2);
    rst_req = 1; tick(); rst_req = 0;
    chk("shdn_rst_state", 32'(pmu_state), 0);
    chk("shdn_rst_gate", 32'(clk_gate), 0);
    ticks(10);

    // Reset extension: request lands after four RESET cycles, giving eight more (twelve total)
    rst_req = 1; tick(); rst_req = 0;
    ticks(3);
    rst_req = 1; tick(); rst_req = 0;
    count_rst(n);
    chk("ext_further", n, H);
    chk("ext_total", n + 4, 12);

    // rst_n during WAKE aborts without any wake event
    shdn_req = 1; tick(); shdn_req = 0;
    btn_wake = 1;
    ticks(18);
    chk("wake_reached", 32'(pmu_state), 3);
    rst_n = 0; tick();
    chk("abort_state", 32'(pmu_state), 0);
    chk("abort_core_rst", 32'(core_rst), 1);
    chk("abort_wake_evt", 32'(wake_evt), 0);
    rst_n = 1; btn_wake = 0;
    e = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (wake_evt) e++; end
    chk("abort_no_evt", e, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) btn_rst = ~btn_rst;
      if ($urandom_range(11) == 0) btn_wake = ~btn_wake;
      rst_req  = ($urandom_range(79) == 0);
      shdn_req = ($urandom_range(11) == 0);
      rst_n    = ($urandom_range(499) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/boa_pmu_ctrl.md
BOA_PMU_CTRL -- requirements
Module: boa_pmu_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed before a button's debounced level changes; SHALL be >= 1.
REQ-002 Parameter RST_HOLD_CYCLES, default 8: number of cycles core_rst is held per reset entry; SHALL be >= 1.
REQ-003 Parameter WAKE_SETTLE_CYCLES, default 2: cycles spent in WAKE before returning to RUN; SHALL be >= 1.
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 btn_rst  input  1  raw asynchronous reset button, active-high.
REQ-007 btn_wake  input  1  raw asynchronous wake button, active-high.
REQ-008 shdn_req  input  1  shutdown request from PMU bus, sampled every cycle.
REQ-009 rst_req  input  1  soft-reset request from PMU bus, sampled every cycle.
REQ-010 core_rst  output  1  active-high reset to the core.
REQ-011 clk_gate  output  1  1 = core clock gated (held high by ORing with clk at top level).
REQ-012 wake_evt  output  1  single-cycle pulse on WAKE -> RUN.
REQ-013 pmu_state  output  2  current state encoding: RESET=0, RUN=1, SHDN=2, WAKE=3.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer with a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-015 The debouncer counter SHALL clear whenever the synchronized input equals the debounced level, and increment otherwise.
REQ-016 The debounced level SHALL flip, and the counter SHALL clear, in the cycle the counter reaches DEBOUNCE_CYCLES-1 while the input still differs.
REQ-017 A press SHALL be the single cycle in which the debounced level goes 0 -> 1; releases SHALL generate no event.
REQ-018 A shared down-counter of width $clog2(max(RST_HOLD_CYCLES, WAKE_SETTLE_CYCLES)+1) SHALL be loaded with HOLD-1 (RESET entry) or SETTLE-1 (WAKE entry) and decrement by 1 per cycle in that state; it SHALL never wrap below 0.
REQ-019 RESET: core_rst=1, clk_gate=0. When counter==0, next state is RUN, so core_rst is high for exactly RST_HOLD_CYCLES cycles.
REQ-020 RUN: core_rst=0, clk_gate=0. Transitions, in priority order:
  - rst press or rst_req -> RESET
  - shdn_req -> SHDN
  - otherwise stay in RUN.
REQ-021 SHDN: core_rst=0, clk_gate=1. Transitions, in priority order:
  - rst press or rst_req -> RESET (clock ungated in the same cycle RESET is entered)
  - wake press -> WAKE
  - shdn_req ignored.
REQ-022 WAKE: core_rst=0, clk_gate=0. Transitions:
  - rst press or rst_req -> RESET
  - counter==0 -> RUN, with wake_evt=1 in the first RUN cycle only.
  - shdn_req is ignored in WAKE.
REQ-023 A wake press in RUN, RESET or WAKE SHALL be ignored.
REQ-024 A reset request in RESET SHALL reload the counter, extending the hold to a full RST_HOLD_CYCLES from that cycle.
REQ-025 Simultaneous reset and shutdown requests SHALL resolve to RESET.
REQ-026 All outputs SHALL be registered; state changes SHALL be visible on outputs one cycle after the triggering input is sampled.

Reset
REQ-027 While rst_n=0 the block SHALL hold:
  - state RESET, counter loaded with RST_HOLD_CYCLES-1
  - core_rst=1, clk_gate=0, wake_evt=0, pmu_state=0
  - synchronizer flops, debounced levels and debounce counters all 0.
REQ-028 After rst_n rises, core_rst SHALL stay 1 for RST_HOLD_CYCLES further cycles.
REQ-029 Asserting rst_n=0 mid-operation (including SHDN or WAKE) SHALL abort immediately to the REQ-027 values at the next clock edge.

Verification
REQ-030 Power-up, defaults: rst_n low 3 cycles then high -> core_rst=1 for 8 cycles, then 0, pmu_state=1; clk_gate=0 throughout.
REQ-031 Shutdown then wake, in RUN: 1-cycle shdn_req pulse -> clk_gate=1 and pmu_state=2 next cycle. Then btn_wake high 20 cycles -> WAKE 2 cycles, then RUN with a single wake_evt pulse, clk_gate=0.
REQ-032 Debounce glitches: btn_rst toggled high for 15 cycles, low 1, high 15 -> no reset. btn_rst high >= 18 cycles (2 sync + 16 debounce) -> RESET entered and core_rst=1 for 8 cycles.
REQ-033 Priority in RUN: rst_req and shdn_req asserted in the same cycle -> RESET, clk_gate stays 0. In SHDN, rst_req -> RESET with clk_gate=0 in the first RESET cycle.
REQ-034 Reset extension: rst_req re-asserted in the 5th RESET cycle -> core_rst held 8 further cycles (12 total).
REQ-035 Mid-operation reset: rst_n pulled low during WAKE -> next edge gives pmu_state=0, core_rst=1, wake_evt=0, and no wake_evt pulse is ever emitted.
